blk_mover: RTL and testbench



---
 rtl/blk_mover.sv | 223 ++++++++++++++++++++++
 tb/tb_blk_mover.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/blk_mover.sv
// blk_mover: debounced five-button sprite-position controller with per-axis
// slow/fast acceleration and clamp-or-wrap playfield bounds.
module blk_mover #(
  parameter int unsigned X_W         = 11,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned X_MIN       = 14,
  parameter int unsigned X_MAX       = 1237,
  parameter int unsigned Y_MIN       = 14,
  parameter int unsigned Y_MAX       = 757,
  parameter int unsigned X_RST       = 471,
  parameter int unsigned Y_RST       = 386,
  parameter int unsigned X_HOME      = 650,
  parameter int unsigned Y_HOME      = 376,
  parameter int unsigned STEP        = 4,
  parameter int unsigned FAST_MUL    = 2,
  parameter int unsigned ACCEL_TICKS = 8,
  parameter int unsigned DEB_TICKS   = 2,
  parameter int unsigned WRAP        = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           btn_u,
  input  logic           btn_d,
  input  logic           btn_l,
  input  logic           btn_r,
  input  logic           btn_c,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           moving
);

  localparam int unsigned BtnU = 0;
  localparam int unsigned BtnD = 1;
  localparam int unsigned BtnL = 2;
  localparam int unsigned BtnR = 3;
  localparam int unsigned BtnC = 4;

  localparam int unsigned DebW  = $clog2(DEB_TICKS + 1);
  // One spare count so the hold counter cannot wrap before reaching the limit.
  localparam int unsigned HoldW = $clog2(ACCEL_TICKS + 2);

  localparam logic [DebW-1:0]  DebLim    = DebW'(DEB_TICKS);
  localparam logic [HoldW-1:0] AccelHold = HoldW'(ACCEL_TICKS);
  localparam logic             WrapEn    = (WRAP != 0);

  localparam logic signed [X_W:0] XMinS  = $signed((X_W+1)'(X_MIN));
  localparam logic signed [X_W:0] XMaxS  = $signed((X_W+1)'(X_MAX));
  localparam logic signed [X_W:0] XSlow  = $signed((X_W+1)'(STEP));
  localparam logic signed [X_W:0] XFast  = $signed((X_W+1)'(STEP * FAST_MUL));
  localparam logic signed [Y_W:0] YMinS  = $signed((Y_W+1)'(Y_MIN));
  localparam logic signed [Y_W:0] YMaxS  = $signed((Y_W+1)'(Y_MAX));
  localparam logic signed [Y_W:0] YSlow  = $signed((Y_W+1)'(STEP));
  localparam logic signed [Y_W:0] YFast  = $signed((Y_W+1)'(STEP * FAST_MUL));

  typedef enum logic [1:0] {StIdle, StSlow, StFast} axis_st_e;

  typedef struct packed {
    axis_st_e         st;
    logic             neg;   // latched direction: 1 = towards the lower bound
    logic [HoldW-1:0] hold;
  } axis_t;

  // mv: 0 = no move, 1 = slow step, 2 = fast step
  typedef struct packed {
    axis_t      ax;
    logic [1:0] mv;
  } axis_step_t;

  localparam axis_t AxisIdle = '{st: StIdle, neg: 1'b0, hold: '0};

  // One tick of the per-axis motion FSM; act = axis has a direction, neg = its sign.
  function automatic axis_step_t axis_next(input axis_t cur, input logic act, input logic neg);
    axis_step_t r;
    r.ax = cur;
    r.mv = 2'd0;
    if (!act) begin
      r.ax.st = StIdle;
    end else begin
      unique case (cur.st)
        StIdle: begin
          r.ax = '{st: StSlow, neg: neg, hold: HoldW'(1)};
          r.mv = 2'd1;
        end
        StSlow: begin
          r.mv = 2'd1;
          if (neg != cur.neg) begin
            r.ax = '{st: StSlow, neg: neg, hold: HoldW'(1)};
          end else begin
            r.ax.hold = cur.hold + 1'b1;
            if (r.ax.hold >= AccelHold) r.ax.st = StFast;
          end
        end
        StFast: begin
          if (neg != cur.neg) begin
            r.ax = '{st: StSlow, neg: neg, hold: HoldW'(1)};
            r.mv = 2'd1;
          end else begin
            r.mv = 2'd2;
          end
        end
        default: r.ax = AxisIdle;
      endcase
    end
    return r;
  endfunction

  logic [4:0]            btn_raw, sync1_q, sync2_q;
  logic [4:0]            deb_q, deb_d;
  logic [4:0][DebW-1:0]  cnt_q, cnt_d;
  axis_t                 ax_x_q, ax_x_d, ax_y_q, ax_y_d;
  axis_step_t            stp_x, stp_y;
  logic [X_W-1:0]        pos_x_q, pos_x_d;
  logic [Y_W-1:0]        pos_y_q, pos_y_d;
  logic                  moving_q, moving_d;
  logic signed [X_W:0]   x_delta, x_sum, x_new;
  logic signed [Y_W:0]   y_delta, y_sum, y_new;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  // Two-flop synchronisers, shifting every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a changed input must persist DEB_TICKS ticks before it is accepted.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (tick) begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] + 1'b1 == DebLim) begin
            deb_d[i] = ~deb_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Axis FSMs and position update; motion uses the debounced state from before this tick.
  always_comb begin
    ax_x_d   = ax_x_q;
    ax_y_d   = ax_y_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    moving_d = moving_q;
    stp_x    = axis_next(ax_x_q, deb_q[BtnR] ^ deb_q[BtnL], deb_q[BtnL]);
    stp_y    = axis_next(ax_y_q, deb_q[BtnD] ^ deb_q[BtnU], deb_q[BtnU]);

    x_delta = '0;
    if (stp_x.mv == 2'd1)      x_delta = XSlow;
    else if (stp_x.mv == 2'd2) x_delta = XFast;
    if (stp_x.ax.neg) x_delta = -x_delta;
    x_sum = $signed({1'b0, pos_x_q}) + x_delta;
    x_new = x_sum;
    if (x_sum > XMaxS)      x_new = WrapEn ? XMinS : XMaxS;
    else if (x_sum < XMinS) x_new = WrapEn ? XMaxS : XMinS;

    y_delta = '0;
    if (stp_y.mv == 2'd1)      y_delta = YSlow;
    else if (stp_y.mv == 2'd2) y_delta = YFast;
    if (stp_y.ax.neg) y_delta = -y_delta;
    y_sum = $signed({1'b0, pos_y_q}) + y_delta;
    y_new = y_sum;
    if (y_sum > YMaxS)      y_new = WrapEn ? YMinS : YMaxS;
    else if (y_sum < YMinS) y_new = WrapEn ? YMaxS : YMinS;

    if (tick) begin
      if (deb_q[BtnC]) begin
        // Centre press overrides the arrows for this tick.
        ax_x_d   = AxisIdle;
        ax_y_d   = AxisIdle;
        pos_x_d  = X_W'(X_HOME);
        pos_y_d  = Y_W'(Y_HOME);
        moving_d = 1'b0;
      end else begin
        ax_x_d   = stp_x.ax;
        ax_y_d   = stp_y.ax;
        pos_x_d  = X_W'(x_new);
        pos_y_d  = Y_W'(y_new);
        moving_d = (stp_x.ax.st != StIdle) || (stp_y.ax.st != StIdle);
      end
    end
  end

  // State registers; synchronous reset wins over tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q    <= '0;
      cnt_q    <= '0;
      ax_x_q   <= AxisIdle;
      ax_y_q   <= AxisIdle;
      pos_x_q  <= X_W'(X_RST);
      pos_y_q  <= Y_W'(Y_RST);
      moving_q <= 1'b0;
    end else begin
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      ax_x_q   <= ax_x_d;
      ax_y_q   <= ax_y_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      moving_q <= moving_d;
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_blk_mover.sv
// Bench for blk_mover: two instances (clamp with default reset, wrap with x reset at the
// lower bound) driven by shared buttons and checked every tick against a tick-level model.
module tb_blk_mover;

  localparam int Step  = 4;
  localparam int Fast  = 8;
  localparam int Accel = 8;
  localparam int Deb   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [4:0]  btn = '0;  // {c, r, l, d, u}
  logic [10:0] px0, px1;
  logic [9:0]  py0, py1;
  logic        mv0, mv1;

  always #5 clk = ~clk;

  blk_mover u_dut0 (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_u(btn[0]), .btn_d(btn[1]), .btn_l(btn[2]), .btn_r(btn[3]), .btn_c(btn[4]),
    .pos_x(px0), .pos_y(py0), .moving(mv0)
  );

  blk_mover #(.WRAP(1), .X_RST(14)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_u(btn[0]), .btn_d(btn[1]), .btn_l(btn[2]), .btn_r(btn[3]), .btn_c(btn[4]),
    .pos_x(px1), .pos_y(py1), .moving(mv1)
  );

  // Reference model state
  int mx[2], my[2];
  bit deb[5];
  int cnt[5];
  int mode[2], ldir[2], hold[2];  // per axis: mode 0 idle, 1 slow, 2 fast
  bit mmov;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int fit(input int v, input int lo, input int hi, input bit wrap);
    if (v > hi) return wrap ? lo : hi;
    if (v < lo) return wrap ? hi : lo;
    return v;
  endfunction

  // Signed displacement for one axis on one tick, given direction -1/0/+1.
  function automatic int step_axis(input int a, input int dir);
    if (dir == 0) begin
      mode[a] = 0;
      return 0;
    end
    if (mode[a] == 0 || dir != ldir[a]) begin
      mode[a] = 1;
      ldir[a] = dir;
      hold[a] = 1;
      return Step * dir;
    end
    if (mode[a] == 1) begin
      hold[a]++;
      if (hold[a] >= Accel) mode[a] = 2;
      return Step * dir;
    end
    return Fast * dir;
  endfunction

  task automatic model_reset();
    mx[0] = 471; mx[1] = 14;
    my[0] = 386; my[1] = 386;
    for (int i = 0; i < 5; i++) begin
      deb[i] = 0;
      cnt[i] = 0;
    end
    for (int a = 0; a < 2; a++) begin
      mode[a] = 0; ldir[a] = 0; hold[a] = 0;
    end
    mmov = 0;
  endtask

  task automatic model_tick();
    bit old[5];
    int dx, dy;
    old = deb;
    for (int i = 0; i < 5; i++) begin
      if (btn[i] != deb[i]) begin
        cnt[i]++;
        if (cnt[i] == Deb) begin
          deb[i] = !deb[i];
          cnt[i] = 0;
        end
      end else begin
        cnt[i] = 0;
      end
    end
    if (old[4]) begin
      for (int d = 0; d < 2; d++) begin
        mx[d] = 650;
        my[d] = 376;
        mode[d] = 0;
      end
    end else begin
      dx = step_axis(0, int'(old[3]) - int'(old[2]));
      dy = step_axis(1, int'(old[1]) - int'(old[0]));
      for (int d = 0; d < 2; d++) begin
        mx[d] = fit(mx[d] + dx, 14, 1237, d == 1);
        my[d] = fit(my[d] + dy, 14, 757, d == 1);
      end
    end
    mmov = (mode[0] != 0) || (mode[1] != 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x0"}, int'(px0), mx[0]);
    check({tag, ".y0"}, int'(py0), my[0]);
    check({tag, ".mv0"}, int'(mv0), int'(mmov));
    check({tag, ".x1"}, int'(px1), mx[1]);
    check({tag, ".y1"}, int'(py1), my[1]);
    check({tag, ".mv1"}, int'(mv1), int'(mmov));
  endtask

  // Ticks are 10 clocks apart; buttons only change just after a tick edge.
  task automatic run_tick(input string tag);
    repeat (9) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    model_tick();
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  task automatic run_ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) run_tick(tag);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_x_const", int'(px0), 471);
    check("rst_y_const", int'(py0), 386);
    run_ticks(20, "idle");

    // Debounce and acceleration
    btn = 5'b01000;
    run_ticks(2, "deb");
    check("no_move_t2", int'(px0), 471);
    run_tick("acc");
    check("t3_x", int'(px0), 475);
    check("t3_moving", int'(mv0), 1);
    run_ticks(7, "acc");
    check("t10_x", int'(px0), 503);
    run_tick("acc");
    check("t11_x", int'(px0), 511);

    // Clamp at the right bound while fast
    run_ticks(100, "clamp");
    check("clamp_x", int'(px0), 1237);

    // Centre priority while fast
    btn = 5'b11000;
    run_ticks(4, "centre");
    check("centre_x", int'(px0), 650);
    check("centre_y", int'(py0), 376);
    check("centre_mv", int'(mv0), 0);

    // Reset mid-hold
    btn = 5'b01000;
    run_ticks(6, "hold");
    do_reset();
    check("midrst_x", int'(px0), 471);
    run_ticks(2, "post_rst");
    check("post_rst_still", int'(px0), 471);
    run_ticks(3, "post_rst");

    // Glitch rejection, diagonal, opposing buttons
    btn = 5'b00001;
    run_tick("glitch");
    btn = 5'b00000;
    run_ticks(4, "glitch");
    btn = 5'b00101;
    run_ticks(6, "diag");
    btn = 5'b00011;
    run_ticks(4, "ud");

    // Wrap at the left bound
    btn = 5'b00000;
    do_reset();
    btn = 5'b00100;
    run_ticks(3, "wrap");
    check("wrap_x1", int'(px1), 1237);
    run_tick("wrap");
    check("wrap_x2", int'(px1), 1233);

    // Randomised phase
    for (int k = 0; k < 60; k++) begin
      logic [4:0] b;
      b = 5'($urandom) & 5'h0f;
      b[4] = ($urandom_range(0, 9) == 0);
      btn = b;
      if ($urandom_range(0, 19) == 0) do_reset();
      run_ticks(int'($urandom_range(1, 12)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
